// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 sizes, scheduler state enum and GF(2^8) xtime
package aes_pkg;

  localparam int AES_NR         = 14;
  localparam int AES_RK_W       = 128;
  localparam int AES256_NUM_RK  = 15;
  localparam int AES256_EXKEY_W = AES_RK_W * AES256_NUM_RK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } dks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes256_dkey_sched_if.sv
// rtl/aes256_dkey_sched_if.sv - key-expansion handshake and decryption key bus
interface aes256_dkey_sched_if;
  import aes_pkg::*;

  logic                      i_key_en;
  logic                      i_key_ok;
  logic [AES256_EXKEY_W-1:0] i_exkey;
  logic [AES256_EXKEY_W-1:0] o_dkey;
  logic                      o_dkey_ok;
  logic                      o_busy;

  modport master (
    output i_key_en, i_key_ok, i_exkey,
    input  o_dkey, o_dkey_ok, o_busy
  );

  modport slave (
    input  i_key_en, i_key_ok, i_exkey,
    output o_dkey, o_dkey_ok, o_busy
  );

endinterface

// File: rtl/aes_inv_mixcol.sv
// rtl/aes_inv_mixcol.sv - combinational 128-bit InvMixColumns built from xtime chains
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [AES_RK_W-1:0] i_state,
  output logic [AES_RK_W-1:0] o_state
);

  // One column: s'_i = 0e*s_i ^ 0b*s_(i+1) ^ 0d*s_(i+2) ^ 09*s_(i+3)
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ s[(i+3)%4]);
    end
    return r;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign o_state[AES_RK_W-1-32*c -: 32] = inv_col(i_state[AES_RK_W-1-32*c -: 32]);
  end

endmodule

// File: rtl/aes256_dkey_sched.sv
// rtl/aes256_dkey_sched.sv - AES-256 decryption round-key scheduler; AES256_EQINV_EN selects equivalent inverse cipher keys
module aes256_dkey_sched
  import aes_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  aes256_dkey_sched_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(AES_NR);

  dks_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ok_q, ok_d;
  logic                kok_q;
  logic                start, conv_we, last, busy;
  logic [AES_RK_W-1:0] src, wdata;
  logic [AES_RK_W-1:0] dk_q [AES256_NUM_RK];

  // Key-ready rising edge, accepted only outside a conversion and never alongside an abort
  assign start = bus.i_key_ok && !kok_q && !bus.i_key_en &&
                 ((state_q == IDLE) || (state_q == DONE));
  assign last  = (cnt_q == CNT_LAST);

  // d_cnt is built from ek_(14-cnt), which sits at [128*cnt +: 128]
  assign src = bus.i_exkey[AES_RK_W*cnt_q +: AES_RK_W];

`ifdef AES256_EQINV_EN
  logic [AES_RK_W-1:0] imc;

  aes_inv_mixcol u_imc (
    .i_state (src),
    .o_state (imc)
  );

  assign wdata = ((cnt_q == 4'd0) || last) ? src : imc;
`else
  assign wdata = src;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: abort beats start, start beats conversion progress
  always_comb begin
    state_d = state_q;
    if (bus.i_key_en)                     state_d = IDLE;
    else if (start)                       state_d = CONV;
    else if ((state_q == CONV) && last)   state_d = DONE;
  end

  // FSM outputs: busy flag and per-cycle key write strobe
  always_comb begin
    busy    = (state_q == CONV);
    conv_we = (state_q == CONV) && !bus.i_key_en;
  end

  // Counter and done-flag next values; the counter parks at 14 instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    ok_d  = ok_q;
    if (bus.i_key_en || start) begin
      cnt_d = '0;
      ok_d  = 1'b0;
    end else if (conv_we) begin
      if (last) ok_d  = 1'b1;
      else      cnt_d = cnt_q + 4'd1;
    end
  end

  // Control registers, including the previous-cycle copy of i_key_ok for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      ok_q  <= 1'b0;
      kok_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ok_q  <= ok_d;
      kok_q <= bus.i_key_ok;
    end
  end

  // Decryption key store: one 128-bit slot written per conversion cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < AES256_NUM_RK; r++) dk_q[r] <= '0;
    end else if (conv_we) begin
      dk_q[cnt_q] <= wdata;
    end
  end

  for (genvar r = 0; r < AES256_NUM_RK; r++) begin : g_pack
    assign bus.o_dkey[AES256_EXKEY_W-1-AES_RK_W*r -: AES_RK_W] = dk_q[r];
  end

  assign bus.o_dkey_ok = ok_q;
  assign bus.o_busy    = busy;

endmodule
